// File: rtl/bram_ptr_streamer_if.sv
// Bus bundle for bram_ptr_streamer: BRAM port-B read side plus the AXIS master.
// The master modport is the streamer's view; slave is the BRAM/sink view.
// LOOP_TLAST_EN adds m_axis_tlast.
`timescale 1ns/1ps
interface bram_ptr_streamer_if #(
  parameter int DATA_W = 512,
  parameter int ADDR_W = 17
) ();
  logic              bram_en;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_rddata;
  logic [DATA_W-1:0] m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
`ifdef LOOP_TLAST_EN
  logic              m_axis_tlast;
`endif

  modport master (
    output bram_en, bram_addr,
    input  bram_rddata,
    output m_axis_tdata, m_axis_tvalid,
    input  m_axis_tready
`ifdef LOOP_TLAST_EN
    , output m_axis_tlast
`endif
  );

  modport slave (
    input  bram_en, bram_addr,
    output bram_rddata,
    input  m_axis_tdata, m_axis_tvalid,
    output m_axis_tready
`ifdef LOOP_TLAST_EN
    , input m_axis_tlast
`endif
  );
endinterface

// File: rtl/bram_ptr_streamer.sv
// bram_ptr_streamer: plays BRAM words start..stop (inclusive) in an endless loop
// onto an AXIS master with full backpressure. Reads are credit-limited so the
// small output FIFO can never overflow. Pointer updates apply at loop boundaries.
// Optional feature macro: LOOP_TLAST_EN (tlast on the last word of each loop).
`timescale 1ns/1ps
module bram_ptr_streamer #(
  parameter int DATA_W = 512,
  parameter int ADDR_W = 17,
  parameter int RD_LAT = 2,
  parameter int FIFO_D = 4
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        enable,
  input  logic [31:0] start_ptr,
  input  logic [31:0] stop_ptr,
  output logic        busy,
  output logic        ptr_err,
  bram_ptr_streamer_if.master bus
);

  localparam int WORD_W = ADDR_W - 6;
  localparam int PTR_W  = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
  localparam int CNT_W  = $clog2(FIFO_D + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              enable_q;
  logic [WORD_W-1:0] sw_q, sw_d, ew_q, ew_d, rd_ptr_q, rd_ptr_d;
  logic              ptr_err_q, ptr_err_d;
  logic [RD_LAT-1:0] vpipe_q, vpipe_d;
  logic [PTR_W-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] data_mem [FIFO_D];
`ifdef LOOP_TLAST_EN
  logic [RD_LAT-1:0] lpipe_q, lpipe_d;
  logic              last_mem [FIFO_D];
`endif

  logic [WORD_W-1:0] in_sw, in_ew;
  logic              enable_rise, issue, at_end, wrap, push, pop, tvalid, drain_enter;
  int                inflight;
  logic              unused_ptr_bits;

  function automatic int popcount(input logic [RD_LAT-1:0] v);
    int n = 0;
    for (int i = 0; i < RD_LAT; i++) n += int'(v[i]);
    return n;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_D - 1)) ? '0 : p + 1'b1;
  endfunction

  // Word indices ignore the sub-word byte bits and anything above the BRAM image.
  assign in_sw = start_ptr[ADDR_W-1:6];
  assign in_ew = stop_ptr[ADDR_W-1:6];
  assign unused_ptr_bits = ^{start_ptr[31:ADDR_W], start_ptr[5:0],
                             stop_ptr[31:ADDR_W], stop_ptr[5:0]};

  assign enable_rise = enable & ~enable_q;
  assign inflight    = popcount(vpipe_q);
  // Credit rule: words in flight plus words buffered never exceed the FIFO depth.
  assign issue       = (state_q == S_RUN) && ((int'(cnt_q) + inflight) < FIFO_D);
  assign at_end      = (rd_ptr_q == ew_q);
  // An inverted range collapses the loop to the single word sw.
  assign wrap        = at_end || (ew_q < sw_q);
  assign push        = vpipe_q[RD_LAT-1] && (state_q == S_RUN);
  assign tvalid      = (cnt_q != '0);
  assign pop         = tvalid && bus.m_axis_tready;
  assign drain_enter = (state_q == S_RUN) && !enable;

  // Next-state logic: FSM, read pointer, latched loop bounds, error flag, read pipe.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path infers a latch.
    state_d   = state_q;
    sw_d      = sw_q;
    ew_d      = ew_q;
    rd_ptr_d  = rd_ptr_q;
    ptr_err_d = ptr_err_q;
    vpipe_d   = vpipe_q << 1;
    vpipe_d[0] = issue;
`ifdef LOOP_TLAST_EN
    lpipe_d    = lpipe_q << 1;
    lpipe_d[0] = issue && at_end;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (enable_rise) begin
          state_d   = S_RUN;
          sw_d      = in_sw;
          ew_d      = in_ew;
          rd_ptr_d  = in_sw;
          ptr_err_d = (in_ew < in_sw);
        end
      end
      S_RUN: begin
        if (issue) begin
          if (wrap) begin
            rd_ptr_d = in_sw;
            sw_d     = in_sw;
            ew_d     = in_ew;
            if (in_ew < in_sw) ptr_err_d = 1'b1;
          end else begin
            rd_ptr_d = rd_ptr_q + 1'b1;
          end
        end
        if (!enable) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if ((vpipe_q == '0) && (cnt_q == '0)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO pointer/count update; entering DRAIN keeps only a beat already on the bus.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (drain_enter) begin
      rd_d  = pop ? ptr_inc(rd_q) : rd_q;
      cnt_d = (tvalid && !pop) ? CNT_W'(1) : '0;
      wr_d  = (tvalid && !pop) ? ptr_inc(rd_q) : rd_d;
    end else begin
      if (push) wr_d = ptr_inc(wr_q);
      if (pop)  rd_d = ptr_inc(rd_q);
      cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q   <= S_IDLE;
      // NOTE: enable history resets high so an enable held across reset is not a start.
      enable_q  <= 1'b1;
      sw_q      <= '0;
      ew_q      <= '0;
      rd_ptr_q  <= '0;
      ptr_err_q <= 1'b0;
      vpipe_q   <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
`ifdef LOOP_TLAST_EN
      lpipe_q   <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q   <= state_d;
      enable_q  <= enable;
      sw_q      <= sw_d;
      ew_q      <= ew_d;
      rd_ptr_q  <= rd_ptr_d;
      ptr_err_q <= ptr_err_d;
      vpipe_q   <= vpipe_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      cnt_q     <= cnt_d;
`ifdef LOOP_TLAST_EN
      lpipe_q   <= lpipe_d;
`endif
    end
  end

  // FIFO storage write: returning BRAM words land at the tail.
  // NOTE: storage is not reset; the count gates every read, so stale contents never escape.
  always_ff @(posedge aclk) begin
    if (push) begin
      data_mem[wr_q] <= bus.bram_rddata;
`ifdef LOOP_TLAST_EN
      last_mem[wr_q] <= lpipe_q[RD_LAT-1];
`endif
    end
  end

  assign bus.bram_en       = issue;
  assign bus.bram_addr     = issue ? {rd_ptr_q, 6'b0} : '0;
  assign bus.m_axis_tvalid = tvalid;
  assign bus.m_axis_tdata  = tvalid ? data_mem[rd_q] : '0;
`ifdef LOOP_TLAST_EN
  assign bus.m_axis_tlast  = tvalid ? last_mem[rd_q] : 1'b0;
`endif
  assign busy              = (state_q != S_IDLE);
  assign ptr_err           = ptr_err_q;

endmodule

// File: tb/tb_bram_ptr_streamer.sv
// Testbench for bram_ptr_streamer: a table of stream scenarios is played through a
// BRAM model (word n = {16{n}}) and each accepted beat is compared with a word
// list built from the loop rules. Hand sequences cover drain and mid-stream reset.
`timescale 1ns/1ps
module tb_bram_ptr_streamer;
  localparam int DATA_W = 512;
  localparam int ADDR_W = 17;
  localparam int RD_LAT = 2;
  localparam int FIFO_D = 4;
  localparam int NVEC   = 10;

  typedef struct {
    logic [31:0] start_p;
    logic [31:0] stop_p;
    logic [31:0] stop_new;   // stop pointer applied one cycle after the start edge
    bit          rand_ready;
    int          nbeats;
    bit          exp_err;
    int          exp_lat;
  } vec_t;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] start_ptr = '0;
  logic [31:0] stop_ptr = '0;
  logic        busy, ptr_err;

  int checks = 0;
  int failures = 0;
  int exp_q[$];
  bit exp_last_q[$];

  bram_ptr_streamer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  bram_ptr_streamer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .FIFO_D(FIFO_D)) dut (
    .aclk(aclk), .aresetn(aresetn), .enable(enable),
    .start_ptr(start_ptr), .stop_ptr(stop_ptr),
    .busy(busy), .ptr_err(ptr_err), .bus(bus)
  );

  always #5 aclk = ~aclk;

  function automatic logic [DATA_W-1:0] word_of(input int n);
    return {(DATA_W/32){32'(n)}};
  endfunction

  // BRAM model: data for the address strobed at an edge appears RD_LAT cycles later.
  logic [DATA_W-1:0] rd_pipe [RD_LAT];
  always @(posedge aclk) begin
    rd_pipe[0] <= bus.bram_en ? word_of(int'(bus.bram_addr >> 6)) : '0;
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bus.bram_rddata = rd_pipe[RD_LAT-1];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
    end
  endtask

  // Expected word order: loop 0 uses ew0, later loops ew1; an inverted range plays sw only.
  task automatic fill_exp(input int sw, input int ew0, input int ew1, input int n);
    int loop_n = 0;
    int ew;
    exp_q.delete();
    exp_last_q.delete();
    while (exp_q.size() < n) begin
      ew = (loop_n == 0) ? ew0 : ew1;
      if (ew < sw) begin
        exp_q.push_back(sw);
        exp_last_q.push_back(1'b0);
      end else begin
        for (int w = sw; w <= ew; w++) begin
          exp_q.push_back(w);
          exp_last_q.push_back(w == ew);
        end
      end
      loop_n++;
    end
  endtask

  task automatic check_beat(input string tag, input int idx);
    check($sformatf("%s%0d word", tag, idx), 64'(bus.m_axis_tdata[31:0]), 64'(exp_q[idx]));
    check($sformatf("%s%0d lanes", tag, idx), 64'(bus.m_axis_tdata == word_of(exp_q[idx])), 64'(1));
`ifdef LOOP_TLAST_EN
    check($sformatf("%s%0d tlast", tag, idx), 64'(bus.m_axis_tlast), 64'(exp_last_q[idx]));
`endif
  endtask

  // Start a stream with an enable rise, collect nbeats, then drain under backpressure.
  // Entered and left just after a rising edge.
  task automatic run_stream(input vec_t v);
    int sw, ew0, ew1, got, cyc, first_seen, wt;
    logic prev_hold;
    logic [DATA_W-1:0] prev_data;
    sw  = int'(v.start_p[ADDR_W-1:6]);
    ew0 = int'(v.stop_p[ADDR_W-1:6]);
    ew1 = int'(v.stop_new[ADDR_W-1:6]);
    fill_exp(sw, ew0, ew1, v.nbeats + 8);
    start_ptr = v.start_p;
    stop_ptr  = v.stop_p;
    bus.m_axis_tready = v.rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    enable = 1'b1;
    got = 0; cyc = 0; first_seen = -1; prev_hold = 1'b0; prev_data = '0;
    while (got < v.nbeats && cyc < v.nbeats * 8 + 40) begin
      @(negedge aclk);
      if (first_seen < 0 && bus.m_axis_tvalid) begin
        first_seen = cyc;
        check("first-word latency", 64'(cyc), 64'(v.exp_lat));
        check("ptr_err", 64'(ptr_err), 64'(v.exp_err));
      end
      if (prev_hold) begin
        check("held tvalid", 64'(bus.m_axis_tvalid), 64'(1));
        check("held tdata stable", 64'(bus.m_axis_tdata == prev_data), 64'(1));
      end
      if (bus.bram_en) check("bram_addr aligned", 64'(bus.bram_addr[5:0]), 64'(0));
      if (bus.m_axis_tvalid && bus.m_axis_tready) begin
        check_beat("beat", got);
        got++;
      end
      prev_hold = bus.m_axis_tvalid && !bus.m_axis_tready;
      prev_data = bus.m_axis_tdata;
      @(posedge aclk); #1;
      if (cyc == 0) stop_ptr = v.stop_new;
      bus.m_axis_tready = v.rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      cyc++;
    end
    if (first_seen < 0) check("first beat seen", 64'(0), 64'(1));
    check("beats received", 64'(got), 64'(v.nbeats));
    // Backpressure, then drop enable: one presented beat must survive the drain.
    bus.m_axis_tready = 1'b0;
    @(posedge aclk); #1;
    enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge aclk);
      check("drain hold tvalid", 64'(bus.m_axis_tvalid), 64'(1));
      check("drain hold busy", 64'(busy), 64'(1));
      check("drain hold tdata", 64'(bus.m_axis_tdata == word_of(exp_q[got])), 64'(1));
      @(posedge aclk); #1;
    end
    bus.m_axis_tready = 1'b1;
    @(negedge aclk);
    check("drain beat tvalid", 64'(bus.m_axis_tvalid), 64'(1));
    check_beat("drain beat", got);
    @(posedge aclk); #1;
    wt = 0;
    do begin
      @(negedge aclk);
      check("tvalid after drain", 64'(bus.m_axis_tvalid), 64'(0));
      wt++;
    end while (busy && wt < RD_LAT + 2);
    check("busy cleared after drain", 64'(busy), 64'(0));
    @(posedge aclk); #1;
  endtask

  initial begin
    vec_t vecs [NVEC];
    int   rs, rl;
    logic stray;
    bus.m_axis_tready = 1'b0;

    // Reset state.
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("reset tvalid", 64'(bus.m_axis_tvalid), 64'(0));
    check("reset tdata", 64'(bus.m_axis_tdata == '0), 64'(1));
    check("reset bram_en", 64'(bus.bram_en), 64'(0));
    check("reset bram_addr", 64'(bus.bram_addr), 64'(0));
    check("reset busy", 64'(busy), 64'(0));
    check("reset ptr_err", 64'(ptr_err), 64'(0));
`ifdef LOOP_TLAST_EN
    check("reset tlast", 64'(bus.m_axis_tlast), 64'(0));
`endif
    @(posedge aclk); #1;
    aresetn = 1'b1;
    @(posedge aclk); #1;

    // start, stop, stop_new, rand_ready, nbeats, exp_err, exp_lat
    vecs[0] = '{32'h0000_0000, 32'h0000_0C00, 32'h0000_0C00, 1'b0, 60, 1'b0, 4}; // full loop, wrap to 0
    vecs[1] = '{32'h0000_0000, 32'h0000_0C00, 32'h0000_0C00, 1'b1, 60, 1'b0, 4}; // same, 50% ready
    vecs[2] = '{32'h0000_0040, 32'h0000_0080, 32'h0000_0100, 1'b0, 10, 1'b0, 4}; // stop moves mid-loop
    vecs[3] = '{32'h0000_0200, 32'h0000_0100, 32'h0000_0100, 1'b0,  8, 1'b1, 4}; // inverted range
    vecs[4] = '{32'h0002_0047, 32'h0002_00C3, 32'h0002_00C3, 1'b1, 12, 1'b0, 4}; // ignored bits, err clears
    vecs[5] = '{32'h0001_FF80, 32'h0001_FFC0, 32'h0001_FFC0, 1'b1,  9, 1'b0, 4}; // top of image
    vecs[6] = '{32'h0000_0140, 32'h0000_0140, 32'h0000_0140, 1'b0,  6, 1'b0, 4}; // single word
    for (int i = 7; i < 9; i++) begin
      rs = $urandom_range(0, 2040);
      rl = $urandom_range(0, 6);
      vecs[i] = '{32'(rs << 6) | 32'($urandom_range(0, 63)),
                  32'((rs + rl) << 6) | 32'($urandom_range(0, 63)),
                  32'h0, (i == 7), 20, 1'b0, 4};
      vecs[i].stop_new = vecs[i].stop_p;
    end
    rs = $urandom_range(8, 2040);
    vecs[9] = '{32'(rs << 6), 32'((rs - int'($urandom_range(1, 8))) << 6), 32'h0, 1'b1, 6, 1'b1, 4};
    vecs[9].stop_new = vecs[9].stop_p;

    for (int i = 0; i < NVEC; i++) run_stream(vecs[i]);

    // Mid-stream reset: abort at once, and a held-high enable must not restart.
    start_ptr = 32'h0;
    stop_ptr  = 32'h0C00;
    bus.m_axis_tready = 1'b1;
    enable = 1'b1;
    repeat (8) @(posedge aclk);
    #1;
    aresetn = 1'b0;
    @(posedge aclk); #1;
    aresetn = 1'b1;
    @(negedge aclk);
    check("post-reset tvalid", 64'(bus.m_axis_tvalid), 64'(0));
    check("post-reset bram_en", 64'(bus.bram_en), 64'(0));
    check("post-reset busy", 64'(busy), 64'(0));
    stray = 1'b0;
    repeat (10) begin
      @(negedge aclk);
      if (bus.m_axis_tvalid || busy || bus.bram_en) stray = 1'b1;
    end
    check("no restart without enable edge", 64'(stray), 64'(0));
    @(posedge aclk); #1;
    enable = 1'b0;
    @(posedge aclk); #1;
    run_stream(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
